counter_sched: RTL

Round-robin scheduler that shares one count engine among `NUM_REQ` requesters. Each requester posts a target count. The block grants the engine to one requester at a time, runs the count from 0 up to the latched target, and pulses `done_o` to that owner. It sits between the per-channel control logic and the counting datapath, and replaces ad-hoc per-channel counters with one shared, fair resource.

---
 rtl/counter_sched_pkg.sv | 30 +++
 rtl/counter_rr_arb.sv | 60 ++++++
 rtl/counter_sched.sv | 121 ++++++++++++
 3 files changed

// File: rtl/counter_sched_pkg.sv
// Shared constants, FSM state codes and bus helpers for the shared count engine.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package counter_sched_pkg;

   localparam int DEF_CNT_WIDTH = 7;
   localparam int DEF_NUM_REQ   = 4;

   // FSM state codes
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // Slot helper works on a padded bus so one function serves any width;
   // NUM_REQ*CNT_WIDTH must fit in BUS_MAX_W and CNT_WIDTH in SLOT_MAX_W.
   localparam int SLOT_MAX_W = 32;
   localparam int BUS_MAX_W  = 512;

   // Return slot k (each w bits wide) of a flattened bus, LSB-aligned.
   function automatic logic [SLOT_MAX_W-1:0] slot_get(
      input logic [BUS_MAX_W-1:0] bus,
      input int unsigned          k,
      input int unsigned          w
   );
      logic [BUS_MAX_W-1:0] sh;
      sh = bus >> (k * w);
      return sh[SLOT_MAX_W-1:0];
   endfunction

endpackage

// File: rtl/counter_rr_arb.sv
// Round-robin arbiter: first request at or after a rotating pointer wins.
// Latency: grant/index are combinational; pointer updates one edge after adv_i.
// Backpressure: none; requests simply remain pending until selected.
module counter_rr_arb #(
   parameter  int NUM_REQ  = 4,
   localparam int ID_WIDTH = $clog2(NUM_REQ)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NUM_REQ-1:0]  req_i,
   input  logic                adv_i,
   input  logic [ID_WIDTH-1:0] adv_owner_i,
   output logic [NUM_REQ-1:0]  gnt_o,
   output logic [ID_WIDTH-1:0] idx_o,
   output logic                vld_o
);

   logic [ID_WIDTH-1:0] ptr_q, ptr_d;
   logic [ID_WIDTH:0]   sum;
   logic [ID_WIDTH-1:0] cand;

   // Scan from the pointer upward, wrapping, and take the first set request.
   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      vld_o = 1'b0;
      sum   = '0;
      cand  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         sum = {1'b0, ptr_q} + (ID_WIDTH+1)'(i);
         if (sum >= (ID_WIDTH+1)'(NUM_REQ)) begin
            sum = sum - (ID_WIDTH+1)'(NUM_REQ);
         end
         cand = sum[ID_WIDTH-1:0];
         if (!vld_o && req_i[cand]) begin
            vld_o       = 1'b1;
            idx_o       = cand;
            gnt_o[cand] = 1'b1;
         end
      end
   end

   // On completion the pointer moves just past the finished owner.
   always_comb begin
      ptr_d = ptr_q;
      if (adv_i) begin
         ptr_d = (adv_owner_i == ID_WIDTH'(NUM_REQ-1)) ? '0 : adv_owner_i + ID_WIDTH'(1);
      end
   end

   // Pointer register; requester 0 has top priority out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/counter_sched.sv
// Shares one 0..target counter among NUM_REQ requesters in round-robin order.
// Latency: grant 1 cycle after request seen in IDLE; done at target+2; IDLE at target+3.
// Backpressure: level requests wait in IDLE arbitration; a running job cannot be aborted.
module counter_sched
   import counter_sched_pkg::*;
#(
   parameter  int CNT_WIDTH = DEF_CNT_WIDTH,
   parameter  int NUM_REQ   = DEF_NUM_REQ,
   localparam int ID_WIDTH  = $clog2(NUM_REQ)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NUM_REQ-1:0]           req_i,
   input  logic [NUM_REQ*CNT_WIDTH-1:0] cnt_val_i,
   output logic [NUM_REQ-1:0]           gnt_o,
   output logic [NUM_REQ-1:0]           done_o,
   output logic [CNT_WIDTH-1:0]         cnt_o,
   output logic                         busy_o,
   output logic [ID_WIDTH-1:0]          owner_o
);

   logic [1:0]           state_q, state_d;
   logic [CNT_WIDTH-1:0] tgt_q, tgt_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic [NUM_REQ-1:0]   gnt_q, gnt_d;
   logic [NUM_REQ-1:0]   done_q, done_d;
   logic                 busy_q, busy_d;
   logic [ID_WIDTH-1:0]  owner_q, owner_d;

   logic [NUM_REQ-1:0]   arb_gnt;
   logic [ID_WIDTH-1:0]  arb_idx;
   logic                 arb_vld;
   logic [BUS_MAX_W-1:0] bus_pad;
   logic [CNT_WIDTH-1:0] tgt_sel;

   counter_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_i       (req_i),
      .adv_i       (state_q == ST_DONE),
      .adv_owner_i (owner_q),
      .gnt_o       (arb_gnt),
      .idx_o       (arb_idx),
      .vld_o       (arb_vld)
   );

   // Target of the would-be winner; only captured on the grant edge.
   assign bus_pad = BUS_MAX_W'(cnt_val_i);
   assign tgt_sel = CNT_WIDTH'(slot_get(bus_pad, 32'(arb_idx), 32'(CNT_WIDTH)));

   // IDLE grants and latches, RUN counts up to target, DONE pulses and releases.
   always_comb begin
      state_d = state_q;
      tgt_d   = tgt_q;
      cnt_d   = cnt_q;
      gnt_d   = gnt_q;
      done_d  = '0;
      busy_d  = busy_q;
      owner_d = owner_q;
      case (state_q)
         ST_IDLE: begin
            if (arb_vld) begin
               state_d = ST_RUN;
               owner_d = arb_idx;
               tgt_d   = tgt_sel;
               cnt_d   = '0;
               gnt_d   = arb_gnt;
               busy_d  = 1'b1;
            end
         end
         ST_RUN: begin
            if (cnt_q == tgt_q) begin
               state_d = ST_DONE;
               done_d  = gnt_q;
            end else begin
               cnt_d = cnt_q + CNT_WIDTH'(1);
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            gnt_d   = '0;
            busy_d  = 1'b0;
            cnt_d   = '0;
         end
         default: begin
            state_d = ST_IDLE;
            gnt_d   = '0;
            busy_d  = 1'b0;
            cnt_d   = '0;
         end
      endcase
   end

   // State and output registers; reset discards any job in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         tgt_q   <= '0;
         cnt_q   <= '0;
         gnt_q   <= '0;
         done_q  <= '0;
         busy_q  <= 1'b0;
         owner_q <= '0;
      end else begin
         state_q <= state_d;
         tgt_q   <= tgt_d;
         cnt_q   <= cnt_d;
         gnt_q   <= gnt_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
         owner_q <= owner_d;
      end
   end

   assign gnt_o   = gnt_q;
   assign done_o  = done_q;
   assign cnt_o   = cnt_q;
   assign busy_o  = busy_q;
   assign owner_o = owner_q;

endmodule
